// File: rtl/crossroad_pkg.sv
// Shared types and constants for the crossroad scheduler: command codes,
// scheduler state encoding, millisecond duration type and a saturating adder.
package crossroad_pkg;

    typedef logic [15:0] ms_t;

    localparam logic [2:0] CMD_ON     = 3'd0;
    localparam logic [2:0] CMD_OFF    = 3'd1;
    localparam logic [2:0] CMD_BLINK  = 3'd2;
    localparam logic [2:0] CMD_GREEN  = 3'd3;
    localparam logic [2:0] CMD_YELLOW = 3'd4;
    localparam logic [2:0] CMD_RED    = 3'd5;

    // Encoding is visible on phase_o, so IDLE must stay at zero.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        BLINK  = 4'd1,
        AR_A   = 4'd2,
        NS_GO  = 4'd3,
        NS_CLR = 4'd4,
        AR_B   = 4'd5,
        EW_GO  = 4'd6,
        EW_CLR = 4'd7
    } state_t;

    // Duration sums clip at the top of the 16-bit range instead of wrapping.
    function automatic ms_t sat_add(input ms_t a, input ms_t b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/crossroad_scheduler_if.sv
// Command channel towards one traffic-light controller.
// Handshake: cmd_valid is a single-cycle strobe with no back-pressure; the
// receiver must take cmd_type/cmd_data in the cycle cmd_valid is high.
// Outside that cycle type and data are driven to zero.
interface crossroad_scheduler_if;
    import crossroad_pkg::*;

    logic [2:0] cmd_type;
    logic       cmd_valid;
    ms_t        cmd_data;

    modport master (output cmd_type, output cmd_valid, output cmd_data);
    modport slave  (input  cmd_type, input  cmd_valid, input  cmd_data);

endinterface

// File: rtl/ms_timer.sv
// Millisecond timebase: a prescaler producing one tick per CLK_PER_MS cycles
// and a saturating ms counter, both cleared by restart. expired is raised on
// the tick that completes the loaded duration, so a state of N ms that
// restarts the timer on entry is left after exactly N*CLK_PER_MS cycles.
module ms_timer
    import crossroad_pkg::*;
#(
    parameter int CLK_PER_MS = 1000
) (
    input  logic clk,
    input  logic srst,
    input  logic restart,
    input  ms_t  load,
    output logic tick,
    output ms_t  elapsed,
    output logic expired
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);

    logic [PW-1:0] pre_q;

    assign tick    = (pre_q == PRE_LAST);
    assign expired = tick && (({1'b0, elapsed} + 17'd1) >= {1'b0, load});

    // Prescaler and ms counter, both restarted at every state entry.
    always_ff @(posedge clk) begin
        if (srst || restart) begin
            pre_q   <= '0;
            elapsed <= '0;
        end else if (tick) begin
            pre_q <= '0;
            if (elapsed != 16'hFFFF) begin
                elapsed <= elapsed + 16'd1;
            end
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

endmodule

// File: rtl/crossroad_scheduler.sv
// Two-approach intersection scheduler driving the NS and EW light controllers
// through green / yellow / all-red phases, with run/stop, night blink and
// runtime green times. Pedestrian requests are handled only when the macro
// CROSSROAD_PED_EN is defined; otherwise ped_req_i is ignored.
module crossroad_scheduler
    import crossroad_pkg::*;
#(
    parameter int CLK_PER_MS   = 1000,
    parameter int ALL_RED_MS   = 2,
    parameter int YELLOW_MS    = 3,
    parameter int MIN_GREEN_MS = 5,
    parameter int PED_WALK_MS  = 8,
    parameter int DEF_GREEN_MS = 20
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  enable_i,
    input  logic                  blink_i,
    input  logic                  cfg_valid_i,
    input  ms_t                   cfg_ns_green_i,
    input  ms_t                   cfg_ew_green_i,
    input  logic                  ped_req_i,
    crossroad_scheduler_if.master ns_cmd,
    crossroad_scheduler_if.master ew_cmd,
    output logic                  ped_walk_o,
    output logic [3:0]            phase_o
);

    localparam ms_t ALL_RED = 16'(ALL_RED_MS);
    localparam ms_t YELLOW  = 16'(YELLOW_MS);

    state_t     state_q, state_d;
    ms_t        dur_q;
    ms_t        ns_green_q, ew_green_q;
    logic       take, to_ns, to_ew, ar_next, ped_cut;
    logic [2:0] type_d;
    ms_t        data_d, ar_dur;
    logic       tick, expired;
    ms_t        elapsed;

    logic       ns_valid_q, ew_valid_q;
    logic [2:0] ns_type_q, ew_type_q;
    ms_t        ns_data_q, ew_data_q;

    ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_timer (
        .clk     (clk_i),
        .srst    (srst_i),
        .restart (take),
        .load    (dur_q),
        .tick    (tick),
        .elapsed (elapsed),
        .expired (expired)
    );

    assign ar_next = (state_d == AR_A) || (state_d == AR_B);

`ifdef CROSSROAD_PED_EN
    logic ped_pending_q, walk_q, min_reached;

    assign min_reached = ({1'b0, elapsed} + 17'd1) >= 17'(MIN_GREEN_MS);
    assign ped_cut     = tick && ped_pending_q && min_reached;
    assign ar_dur      = ped_pending_q ? sat_add(ALL_RED, 16'(PED_WALK_MS)) : ALL_RED;
    assign ped_walk_o  = walk_q;

    // Sticky request; a request in the clearing cycle itself survives.
    always_ff @(posedge clk_i) begin
        if (srst_i)               ped_pending_q <= 1'b0;
        else if (ped_req_i)       ped_pending_q <= 1'b1;
        else if (take && ar_next) ped_pending_q <= 1'b0;
    end

    // Walk is held for the whole all-red state that served a request.
    always_ff @(posedge clk_i) begin
        if (srst_i)    walk_q <= 1'b0;
        else if (take) walk_q <= ar_next && ped_pending_q;
    end
`else
    logic unused_ped;

    assign ped_cut    = 1'b0;
    assign ar_dur     = ALL_RED;
    assign ped_walk_o = 1'b0;
    assign unused_ped = ^{ped_req_i, tick, elapsed};
`endif

    // Next-state decision and the command it produces (disable > blink > sequence).
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        to_ns   = 1'b0;
        to_ew   = 1'b0;
        type_d  = CMD_ON;
        data_d  = '0;
        if (state_q != IDLE && !enable_i) begin
            state_d = IDLE;  take = 1'b1; to_ns = 1'b1; to_ew = 1'b1; type_d = CMD_OFF;
        end else if (enable_i && blink_i && state_q != BLINK) begin
            state_d = BLINK; take = 1'b1; to_ns = 1'b1; to_ew = 1'b1; type_d = CMD_BLINK;
        end else begin
            case (state_q)
                IDLE, BLINK: if ((state_q == IDLE) ? enable_i : !blink_i) begin
                    state_d = AR_A; take = 1'b1; to_ns = 1'b1; to_ew = 1'b1;
                    type_d = CMD_ON; data_d = ar_dur;
                end
                AR_A: if (expired) begin
                    state_d = NS_GO; take = 1'b1; to_ns = 1'b1;
                    type_d = CMD_GREEN; data_d = ns_green_q;
                end
                NS_GO: if (expired || ped_cut) begin
                    state_d = NS_CLR; take = 1'b1; to_ns = 1'b1;
                    type_d = CMD_YELLOW; data_d = YELLOW;
                end
                NS_CLR: if (expired) begin
                    state_d = AR_B; take = 1'b1; to_ns = 1'b1;
                    type_d = CMD_RED; data_d = ar_dur;
                end
                AR_B: if (expired) begin
                    state_d = EW_GO; take = 1'b1; to_ew = 1'b1;
                    type_d = CMD_GREEN; data_d = ew_green_q;
                end
                EW_GO: if (expired || ped_cut) begin
                    state_d = EW_CLR; take = 1'b1; to_ew = 1'b1;
                    type_d = CMD_YELLOW; data_d = YELLOW;
                end
                EW_CLR: if (expired) begin
                    state_d = AR_A; take = 1'b1; to_ew = 1'b1;
                    type_d = CMD_RED; data_d = ar_dur;
                end
                default: begin
                    state_d = IDLE; take = 1'b1;
                end
            endcase
        end
    end

    // State register; the duration of the entered state is latched with it.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            dur_q   <= '0;
        end else if (take) begin
            state_q <= state_d;
            dur_q   <= data_d;
        end
    end

    // Green-time registers; zero is clamped to 1 ms.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ns_green_q <= 16'(DEF_GREEN_MS);
            ew_green_q <= 16'(DEF_GREEN_MS);
        end else if (cfg_valid_i) begin
            ns_green_q <= (cfg_ns_green_i == '0) ? 16'd1 : cfg_ns_green_i;
            ew_green_q <= (cfg_ew_green_i == '0) ? 16'd1 : cfg_ew_green_i;
        end
    end

    // Registered one-cycle command strobes per channel.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ns_valid_q <= 1'b0; ns_type_q <= '0; ns_data_q <= '0;
            ew_valid_q <= 1'b0; ew_type_q <= '0; ew_data_q <= '0;
        end else begin
            ns_valid_q <= to_ns;
            ns_type_q  <= to_ns ? type_d : 3'd0;
            ns_data_q  <= to_ns ? data_d : '0;
            ew_valid_q <= to_ew;
            ew_type_q  <= to_ew ? type_d : 3'd0;
            ew_data_q  <= to_ew ? data_d : '0;
        end
    end

    assign ns_cmd.cmd_valid = ns_valid_q;
    assign ns_cmd.cmd_type  = ns_type_q;
    assign ns_cmd.cmd_data  = ns_data_q;
    assign ew_cmd.cmd_valid = ew_valid_q;
    assign ew_cmd.cmd_type  = ew_type_q;
    assign ew_cmd.cmd_data  = ew_data_q;
    assign phase_o          = state_q;

endmodule
